if_id_hazard_reg: RTL and testbench

- IF/ID pipeline register with integrated load-use hazard detection and branch flush.
- Sits between instruction fetch and decode. Its outputs feed the register file, control unit and the ID/EX register.
- Generates PC-write enable and a bubble request; ID/EX-side control is zeroed when `bubble=1`.
- Saturating stall and flush counters for performance debug.

---
 rtl/if_id_hazard_reg_if.sv | 29 ++
 rtl/if_id_hazard_reg.sv | 84 ++++++++
 tb/tb_if_id_hazard_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/if_id_hazard_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs, ID/EX hazard sideband, and decode-side outputs.
interface if_id_hazard_reg_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic [PC_W-1:0]    pcIn;
  logic [INSTR_W-1:0] instructionIn;
  logic               branchTaken;
  logic               idExMemRead;
  logic [4:0]         idExRegisterTarget;
  logic [PC_W-1:0]    pcOut;
  logic [INSTR_W-1:0] instructionOut;
  logic               validOut;
  logic               pcWrite;
  logic               bubble;
  logic [CNT_W-1:0]   stallCount;
  logic [CNT_W-1:0]   flushCount;

  modport master (
    output pcIn, instructionIn, branchTaken, idExMemRead, idExRegisterTarget,
    input  pcOut, instructionOut, validOut, pcWrite, bubble, stallCount, flushCount
  );

  modport slave (
    input  pcIn, instructionIn, branchTaken, idExMemRead, idExRegisterTarget,
    output pcOut, instructionOut, validOut, pcWrite, bubble, stallCount, flushCount
  );
endinterface

// File: rtl/if_id_hazard_reg.sv
// IF/ID register, 1-cycle fetch->decode; load-use hazard holds the stage and requests a bubble,
// and a taken branch squashes the held instruction and overrides any stall.
module if_id_hazard_reg #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  if_id_hazard_reg_if.slave   bus
);

  typedef enum logic {RUN, STALL} mode_t;

  logic [PC_W-1:0]    pcQ;
  logic [INSTR_W-1:0] instrQ;
  logic               validQ;
  logic [CNT_W-1:0]   stallQ;
  logic [CNT_W-1:0]   flushQ;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       usesRt;
  logic       hazard;
  mode_t      mode;

  // Only R-type, sw and the two compare branches read rt; elsewhere rt is a destination.
  always_comb begin
    opcode = instrQ[31:26];
    rs     = instrQ[25:21];
    rt     = instrQ[20:16];
    usesRt = (opcode == 6'h00) || (opcode == 6'h2B) ||
             (opcode == 6'h04) || (opcode == 6'h05);
    hazard = validQ && bus.idExMemRead && (bus.idExRegisterTarget != 5'd0) &&
             ((rs == bus.idExRegisterTarget) ||
              (usesRt && (rt == bus.idExRegisterTarget)));
  end

  // The pipeline registers themselves carry the stall; the mode is decided fresh each cycle.
  always_comb begin
    mode = RUN;
    if (!reset && hazard && !bus.branchTaken) begin
      mode = STALL;
    end
  end

  always_comb begin
    bus.pcWrite = (mode == RUN);
    bus.bubble  = (mode == STALL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcQ    <= '0;
      instrQ <= '0;
      validQ <= 1'b0;
      stallQ <= '0;
      flushQ <= '0;
    end else if (bus.branchTaken) begin
      pcQ    <= bus.pcIn;
      instrQ <= '0;
      validQ <= 1'b0;
      if (flushQ != {CNT_W{1'b1}}) begin
        flushQ <= flushQ + 1'b1;
      end
    end else if (mode == STALL) begin
      if (stallQ != {CNT_W{1'b1}}) begin
        stallQ <= stallQ + 1'b1;
      end
    end else begin
      pcQ    <= bus.pcIn;
      instrQ <= bus.instructionIn;
      validQ <= 1'b1;
    end
  end

  assign bus.pcOut          = pcQ;
  assign bus.instructionOut = instrQ;
  assign bus.validOut       = validQ;
  assign bus.stallCount     = stallQ;
  assign bus.flushCount     = flushQ;

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Directed bench: a default-width instance for function/priority, a CNT_W=2 instance for saturation.
module tb_if_id_hazard_reg;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  if_id_hazard_reg_if #(.PC_W(7), .INSTR_W(32), .CNT_W(16)) busA ();
  if_id_hazard_reg_if #(.PC_W(7), .INSTR_W(32), .CNT_W(2))  busB ();

  if_id_hazard_reg #(.PC_W(7), .INSTR_W(32), .CNT_W(16)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  if_id_hazard_reg #(.PC_W(7), .INSTR_W(32), .CNT_W(2)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic driveA(input logic [6:0] pc, input logic [31:0] instr,
                        input logic br, input logic mr, input logic [4:0] tgt);
    busA.pcIn               = pc;
    busA.instructionIn      = instr;
    busA.branchTaken        = br;
    busA.idExMemRead        = mr;
    busA.idExRegisterTarget = tgt;
    #1;
  endtask

  initial begin
    // Reset with random inputs on A; B sits idle so it never stalls until its own test.
    reset = 1'b1;
    driveA(7'($urandom), $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)));
    busB.pcIn = '0; busB.instructionIn = '0; busB.branchTaken = 1'b0;
    busB.idExMemRead = 1'b0; busB.idExRegisterTarget = '0;
    tick();
    driveA(7'($urandom), $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)));
    tick();
    check("rst_pcOut", 64'(busA.pcOut), 64'd0);
    check("rst_instr", 64'(busA.instructionOut), 64'd0);
    check("rst_valid", 64'(busA.validOut), 64'd0);
    check("rst_stall", 64'(busA.stallCount), 64'd0);
    check("rst_flush", 64'(busA.flushCount), 64'd0);
    check("rst_pcWrite", 64'(busA.pcWrite), 64'd1);
    check("rst_bubble", 64'(busA.bubble), 64'd0);

    // Pass-through
    reset = 1'b0;
    driveA(7'd5, 32'h012A4020, 1'b0, 1'b0, 5'd0);
    check("pt_pcWrite_pre", 64'(busA.pcWrite), 64'd1);
    tick();
    check("pt_pcOut", 64'(busA.pcOut), 64'd5);
    check("pt_instr", 64'(busA.instructionOut), 64'h012A4020);
    check("pt_valid", 64'(busA.validOut), 64'd1);
    check("pt_pcWrite", 64'(busA.pcWrite), 64'd1);

    // Load-use on rs ($9)
    driveA(7'd6, 32'h21490004, 1'b0, 1'b1, 5'd9);
    check("lu_bubble", 64'(busA.bubble), 64'd1);
    check("lu_pcWrite", 64'(busA.pcWrite), 64'd0);
    tick();
    check("lu_hold_pc", 64'(busA.pcOut), 64'd5);
    check("lu_hold_instr", 64'(busA.instructionOut), 64'h012A4020);
    check("lu_stall1", 64'(busA.stallCount), 64'd1);
    driveA(7'd6, 32'h21490004, 1'b0, 1'b0, 5'd9);
    check("lu_clear_bubble", 64'(busA.bubble), 64'd0);
    tick();
    check("lu_adv_pc", 64'(busA.pcOut), 64'd6);
    check("lu_adv_instr", 64'(busA.instructionOut), 64'h21490004);
    check("lu_stall_kept", 64'(busA.stallCount), 64'd1);

    // addi: rt is a destination, only rs ($10) matters
    driveA(7'd7, 32'h0, 1'b0, 1'b1, 5'd9);
    check("addi_rt_bubble", 64'(busA.bubble), 64'd0);
    check("addi_rt_pcWrite", 64'(busA.pcWrite), 64'd1);
    driveA(7'd7, 32'h0, 1'b0, 1'b1, 5'd10);
    check("addi_rs_bubble", 64'(busA.bubble), 64'd1);
    check("addi_rs_pcWrite", 64'(busA.pcWrite), 64'd0);

    // Flush wins over a simultaneous hazard
    driveA(7'd20, 32'h012A4020, 1'b1, 1'b1, 5'd10);
    check("fl_pcWrite", 64'(busA.pcWrite), 64'd1);
    check("fl_bubble", 64'(busA.bubble), 64'd0);
    tick();
    check("fl_valid", 64'(busA.validOut), 64'd0);
    check("fl_instr", 64'(busA.instructionOut), 64'd0);
    check("fl_pcOut", 64'(busA.pcOut), 64'd20);
    check("fl_flush", 64'(busA.flushCount), 64'd1);
    check("fl_stall", 64'(busA.stallCount), 64'd1);

    // sw $8,0($9): rt is a source
    driveA(7'd21, 32'hAD280000, 1'b0, 1'b0, 5'd0);
    tick();
    driveA(7'd22, 32'h00000020, 1'b0, 1'b1, 5'd8);
    check("sw_rt_bubble", 64'(busA.bubble), 64'd1);
    tick();
    check("sw_hold_instr", 64'(busA.instructionOut), 64'hAD280000);
    check("sw_stall2", 64'(busA.stallCount), 64'd2);

    // $0 never hazards
    driveA(7'd22, 32'h00000020, 1'b0, 1'b0, 5'd0);
    tick();
    driveA(7'd23, 32'h012A4020, 1'b0, 1'b1, 5'd0);
    check("r0_instr", 64'(busA.instructionOut), 64'h00000020);
    check("r0_bubble", 64'(busA.bubble), 64'd0);
    check("r0_pcWrite", 64'(busA.pcWrite), 64'd1);

    // Reset mid-stall: R-type reads rt=$10
    driveA(7'd23, 32'h012A4020, 1'b0, 1'b0, 5'd0);
    tick();
    driveA(7'd24, 32'h0, 1'b0, 1'b1, 5'd10);
    check("rt_rtype_bubble", 64'(busA.bubble), 64'd1);
    tick();
    check("rt_rtype_stall3", 64'(busA.stallCount), 64'd3);
    reset = 1'b1;
    #1;
    check("mrst_pcWrite", 64'(busA.pcWrite), 64'd1);
    check("mrst_bubble", 64'(busA.bubble), 64'd0);
    tick();
    check("mrst_stall", 64'(busA.stallCount), 64'd0);
    check("mrst_flush", 64'(busA.flushCount), 64'd0);
    check("mrst_valid", 64'(busA.validOut), 64'd0);
    check("mrst_pcOut", 64'(busA.pcOut), 64'd0);
    reset = 1'b0;
    driveA(7'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Saturation on the 2-bit counter instance
    busB.pcIn = 7'd3; busB.instructionIn = 32'h012A4020;
    busB.idExMemRead = 1'b0; busB.idExRegisterTarget = 5'd0;
    tick();
    busB.pcIn = 7'd4; busB.idExMemRead = 1'b1; busB.idExRegisterTarget = 5'd9;
    tick();
    check("sat_stall1", 64'(busB.stallCount), 64'd1);
    tick();
    tick();
    check("sat_stall3", 64'(busB.stallCount), 64'd3);
    tick();
    tick();
    check("sat_stall5", 64'(busB.stallCount), 64'd3);
    check("sat_hold_pc", 64'(busB.pcOut), 64'd3);
    check("sat_bubble", 64'(busB.bubble), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
